udp_rx_checker: RTL and testbench
=================================

UDP_RX_CHECKER -- requirements
Module: udp_rx_checker

Interface
REQ-001 The block SHALL expose these ports: gmii_rx_clk in 1, sole clock, all logic on rising edge.
REQ-002 The block SHALL expose rst_n in 1, asynchronous active-low reset.
REQ-003 The block SHALL expose gmii_rx_dv in 1, frame-valid strobe, sampled each gmii_rx_clk edge.
REQ-004 The block SHALL expose gmii_rxd in 8, one received byte per cycle while gmii_rx_dv=1.
REQ-005 The block SHALL expose local_mac_addr in 48, local_ip_addr in 32 and local_udp_port in 16, all static filter values.
REQ-006 The block SHALL expose pkt_done out 1, a one-cycle pulse marking end of frame evaluation.
REQ-007 The block SHALL expose pkt_ok out 1, valid with pkt_done, set when the frame passed every check.
REQ-008 The block SHALL expose err_code out 3, valid with pkt_done.
REQ-009 The block SHALL expose payload_len out 16, valid with pkt_done; it equals UDP length minus 8, or 0 if the UDP header was not reached.
REQ-010 The block SHALL expose good_cnt out 32 and err_cnt out 32, both frame counters.

Function
REQ-011 The FSM SHALL have these states: SYNC, IDLE, PREAMBLE, ETH_HDR (14 B), IP_HDR (20 B), UDP_HDR (8 B), PAYLOAD, TAIL (padding+FCS), DROP.
REQ-012 After reset the FSM SHALL enter SYNC, move to IDLE on the first cycle with gmii_rx_dv=0, and report nothing for a frame already in progress.
REQ-013 In IDLE, when gmii_rx_dv=1 with byte 0x55, the FSM SHALL go to PREAMBLE; any other first byte gives code 1 and DROP.
REQ-014 In PREAMBLE, 1-7 total 0x55 bytes followed by 0xD5 SHALL advance to ETH_HDR; an 8th 0x55 or any other byte gives code 1 and DROP.
REQ-015 ETH_HDR: a destination MAC that is neither local_mac_addr nor FF:FF:FF:FF:FF:FF SHALL give code 2; an ethertype other than 0x0800 SHALL give code 3.
REQ-016 IP_HDR: version/IHL other than 0x45, protocol other than 17, or destination IP other than local_ip_addr SHALL give code 4.
REQ-017 UDP_HDR: a destination port other than local_udp_port SHALL give code 5; a length field below 8 SHALL give code 7.
REQ-018 PAYLOAD byte k SHALL equal P[k mod 20], with P = "HELLO ALINX HEIJIN\r\n" (0x48,0x45,0x4C,0x4C,0x4F,0x20,0x41,0x4C,0x49,0x4E,0x58,0x20,0x48,0x45,0x49,0x4A,0x49,0x4E,0x0D,0x0A); the first mismatch SHALL latch code 6 while reception continues.
REQ-019 Bytes after the payload SHALL be ignored except for the FCS; the payload length counter SHALL be 16 bits.
REQ-020 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) SHALL run over all bytes from the destination MAC through the FCS; a residue other than 0xC704DD7B at frame end gives code 7.
REQ-021 If gmii_rx_dv falls before the payload is complete, the block SHALL report code 7 (truncated).
REQ-022 Codes 2-5 SHALL move the FSM to DROP; a code-1 or code-7 header failure SHALL also move it to DROP. DROP waits for gmii_rx_dv=0 and then reports.
REQ-023 Error priority: the first detected code SHALL win, except that code 7 (FCS) overrides code 6.
REQ-024 err_code SHALL be 0 when the frame is OK.
REQ-025 pkt_done SHALL pulse exactly once per frame, on the cycle after the first sample of gmii_rx_dv=0.
REQ-026 pkt_ok, err_code and payload_len SHALL hold their values until the next pkt_done.
REQ-027 good_cnt SHALL increment when pkt_ok=1, err_cnt SHALL increment on codes 1, 6 and 7, and filtered codes 2-5 SHALL increment neither.
REQ-028 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-029 A frame may start on the cycle immediately after gmii_rx_dv falls; the block SHALL accept it and still produce pkt_done for the previous frame.

Reset
REQ-030 On rst_n=0 the block SHALL set pkt_done=0, pkt_ok=0, err_code=0, payload_len=0, good_cnt=0 and err_cnt=0, clear the CRC and byte counters, and put the FSM in SYNC, all asynchronously.
REQ-031 Reset asserted mid-frame SHALL discard the frame without any pkt_done pulse.

Verification
REQ-032 Valid frame (7x55, D5, dst=local MAC, IP 192.168.0.3, port 0x1F90, UDP len 28, 20-byte pattern, good FCS) SHALL give pkt_done with pkt_ok=1, err_code=0, payload_len=20, good_cnt=1.
REQ-033 The same frame with payload byte 5 changed to 0x21 SHALL give err_code=6 and err_cnt=1.
REQ-034 The same frame with the last FCS byte inverted SHALL give err_code=7 and err_cnt=1.
REQ-035 An ARP frame (ethertype 0x0806) SHALL give err_code=3 and leave both counters unchanged; a frame with port 0x1F91 SHALL give err_code=5.
REQ-036 gmii_rx_dv dropped after payload byte 10 SHALL give err_code=7 and payload_len=20.
REQ-037 rst_n pulsed mid-payload with gmii_rx_dv held high SHALL give no pkt_done; the next complete valid frame SHALL give pkt_ok=1 and good_cnt=1.
REQ-038 Two back-to-back frames with a one-cycle gap SHALL give two pkt_done pulses and good_cnt=2.

Source files
------------

// File: rtl/udp_rx_checker.sv
// UDP receive checker: parses a GMII byte stream (preamble, Ethernet, IPv4, UDP),
// filters on local MAC/IP/port, checks a repeating payload pattern and the FCS,
// and reports one result per frame plus saturating good/error frame counters.
module udp_rx_checker (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [15:0] local_udp_port,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [2:0]  err_code,
  output logic [15:0] payload_len,
  output logic [31:0] good_cnt,
  output logic [31:0] err_cnt
);

  typedef enum logic [3:0] {
    SYNC, IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  pidx_q, pidx_d;
  logic [31:0] crc_q, crc_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] plen_q, plen_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic        mac_ok_q, mac_ok_d;
  logic        bcast_q, bcast_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] payload_len_q, payload_len_d;
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  logic [31:0] crc_next;
  logic        residue_ok;
  logic [7:0]  mac_byte, ip_byte;
  logic [15:0] udp_len;
  logic        rep;
  logic [2:0]  rep_code;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

  // Expected payload is "HELLO ALINX HEIJIN\r\n" repeated.
  function automatic logic [7:0] pat_byte(input logic [4:0] i);
    case (i)
      5'd0, 5'd12:  return 8'h48;
      5'd1, 5'd13:  return 8'h45;
      5'd2, 5'd3, 5'd7: return 8'h4C;
      5'd4:         return 8'h4F;
      5'd5, 5'd11:  return 8'h20;
      5'd6:         return 8'h41;
      5'd8, 5'd14, 5'd16: return 8'h49;
      5'd9, 5'd17:  return 8'h4E;
      5'd10:        return 8'h58;
      5'd15:        return 8'h4A;
      5'd18:        return 8'h0D;
      default:      return 8'h0A;
    endcase
  endfunction

  // Select the filter byte matching the current header offset (first byte is MSB).
  always_comb begin
    mac_byte = 8'h00;
    ip_byte  = 8'h00;
    case (cnt_q[2:0])
      3'd0: mac_byte = local_mac_addr[47:40];
      3'd1: mac_byte = local_mac_addr[39:32];
      3'd2: mac_byte = local_mac_addr[31:24];
      3'd3: mac_byte = local_mac_addr[23:16];
      3'd4: mac_byte = local_mac_addr[15:8];
      3'd5: mac_byte = local_mac_addr[7:0];
      default: mac_byte = 8'h00;
    endcase
    case (cnt_q[1:0])
      2'd0: ip_byte = local_ip_addr[31:24];
      2'd1: ip_byte = local_ip_addr[23:16];
      2'd2: ip_byte = local_ip_addr[15:8];
      default: ip_byte = local_ip_addr[7:0];
    endcase
  end

  assign crc_next   = crc_byte(crc_q, gmii_rxd);
  assign residue_ok = (bit_rev32(crc_q) == 32'hC704_DD7B);
  assign udp_len    = {len_hi_q, gmii_rxd};

  // Next-state, header/payload checks and the end-of-frame report.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pidx_d        = pidx_q;
    crc_d         = crc_q;
    err_d         = err_q;
    plen_d        = plen_q;
    len_hi_d      = len_hi_q;
    mac_ok_d      = mac_ok_q;
    bcast_d       = bcast_q;
    pkt_done_d    = 1'b0;
    pkt_ok_d      = pkt_ok_q;
    err_code_d    = err_code_q;
    payload_len_d = payload_len_q;
    good_cnt_d    = good_cnt_q;
    err_cnt_d     = err_cnt_q;
    rep           = 1'b0;
    rep_code      = 3'd0;

    case (state_q)
      SYNC: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      IDLE: begin
        if (gmii_rx_dv) begin
          err_d  = 3'd0;
          plen_d = 16'd0;
          cnt_d  = 16'd1;
          if (gmii_rxd == 8'h55) begin
            state_d = PREAMBLE;
          end else begin
            err_d   = 3'd1;
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = 3'd7;
        end else if (gmii_rxd == 8'h55) begin
          if (cnt_q == 16'd7) begin
            err_d = 3'd1; state_d = DROP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (gmii_rxd == 8'hD5) begin
          state_d  = ETH_HDR;
          cnt_d    = 16'd0;
          crc_d    = 32'hFFFF_FFFF;
          mac_ok_d = 1'b1;
          bcast_d  = 1'b1;
        end else begin
          err_d = 3'd1; state_d = DROP;
        end
      end
      ETH_HDR: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = 3'd7;
        end else begin
          crc_d = crc_next;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q < 16'd6) begin
            mac_ok_d = mac_ok_q & (gmii_rxd == mac_byte);
            bcast_d  = bcast_q & (gmii_rxd == 8'hFF);
            if (cnt_q == 16'd5 && !mac_ok_d && !bcast_d) begin
              err_d = 3'd2; state_d = DROP;
            end
          end else if (cnt_q == 16'd12 && gmii_rxd != 8'h08) begin
            err_d = 3'd3; state_d = DROP;
          end else if (cnt_q == 16'd13) begin
            if (gmii_rxd != 8'h00) begin
              err_d = 3'd3; state_d = DROP;
            end else begin
              state_d = IP_HDR; cnt_d = 16'd0;
            end
          end
        end
      end
      IP_HDR: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = 3'd7;
        end else begin
          crc_d = crc_next;
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q == 16'd0 && gmii_rxd != 8'h45) ||
              (cnt_q == 16'd9 && gmii_rxd != 8'd17) ||
              (cnt_q >= 16'd16 && gmii_rxd != ip_byte)) begin
            err_d = 3'd4; state_d = DROP;
          end else if (cnt_q == 16'd19) begin
            state_d = UDP_HDR; cnt_d = 16'd0;
          end
        end
      end
      UDP_HDR: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = 3'd7;
        end else begin
          crc_d = crc_next;
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q == 16'd2 && gmii_rxd != local_udp_port[15:8]) ||
              (cnt_q == 16'd3 && gmii_rxd != local_udp_port[7:0])) begin
            err_d = 3'd5; state_d = DROP;
          end else if (cnt_q == 16'd4) begin
            len_hi_d = gmii_rxd;
          end else if (cnt_q == 16'd5) begin
            if (udp_len < 16'd8) begin
              err_d = 3'd7; state_d = DROP;
            end else begin
              plen_d = udp_len - 16'd8;
            end
          end else if (cnt_q == 16'd7) begin
            cnt_d   = 16'd0;
            pidx_d  = 5'd0;
            state_d = (plen_q == 16'd0) ? TAIL : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = 3'd7;
        end else begin
          crc_d = crc_next;
          if (gmii_rxd != pat_byte(pidx_q) && err_q == 3'd0) err_d = 3'd6;
          pidx_d = (pidx_q == 5'd19) ? 5'd0 : pidx_q + 5'd1;
          if (cnt_q == plen_q - 16'd1) begin
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      TAIL: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = residue_ok ? err_q : 3'd7;
        end else begin
          crc_d = crc_next;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) begin
          rep = 1'b1; rep_code = err_q;
        end
      end
      default: state_d = SYNC;
    endcase

    if (rep) begin
      state_d       = IDLE;
      pkt_done_d    = 1'b1;
      pkt_ok_d      = (rep_code == 3'd0);
      err_code_d    = rep_code;
      payload_len_d = plen_q;
      if (rep_code == 3'd0) begin
        if (good_cnt_q != 32'hFFFF_FFFF) good_cnt_d = good_cnt_q + 32'd1;
      end else if (rep_code == 3'd1 || rep_code == 3'd6 || rep_code == 3'd7) begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
      end
    end
  end

  // State and result registers; reset drops any frame in progress silently.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      cnt_q         <= 16'd0;
      pidx_q        <= 5'd0;
      crc_q         <= 32'd0;
      err_q         <= 3'd0;
      plen_q        <= 16'd0;
      len_hi_q      <= 8'd0;
      mac_ok_q      <= 1'b0;
      bcast_q       <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_ok_q      <= 1'b0;
      err_code_q    <= 3'd0;
      payload_len_q <= 16'd0;
      good_cnt_q    <= 32'd0;
      err_cnt_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pidx_q        <= pidx_d;
      crc_q         <= crc_d;
      err_q         <= err_d;
      plen_q        <= plen_d;
      len_hi_q      <= len_hi_d;
      mac_ok_q      <= mac_ok_d;
      bcast_q       <= bcast_d;
      pkt_done_q    <= pkt_done_d;
      pkt_ok_q      <= pkt_ok_d;
      err_code_q    <= err_code_d;
      payload_len_q <= payload_len_d;
      good_cnt_q    <= good_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign pkt_done    = pkt_done_q;
  assign pkt_ok      = pkt_ok_q;
  assign err_code    = err_code_q;
  assign payload_len = payload_len_q;
  assign good_cnt    = good_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_udp_rx_checker.sv
// Scoreboard bench for udp_rx_checker: frames are built with a software FCS,
// the expected report is queued when a frame is driven and checked on pkt_done.
module tb_udp_rx_checker;

  logic        clk;
  logic        rst_n;
  logic        dv;
  logic [7:0]  rxd;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic [15:0] local_port;
  logic        pkt_done;
  logic        pkt_ok;
  logic [2:0]  err_code;
  logic [15:0] payload_len;
  logic [31:0] good_cnt;
  logic [31:0] err_cnt;

  typedef struct {
    logic        ok;
    logic [2:0]  code;
    logic [15:0] plen;
    logic [31:0] good;
    logic [31:0] errs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frame_q[$];
  logic [7:0] pattern[20];
  int         checks;
  int         errors;
  logic [31:0] good_exp;
  logic [31:0] err_exp;

  udp_rx_checker dut (
    .gmii_rx_clk   (clk),
    .rst_n         (rst_n),
    .gmii_rx_dv    (dv),
    .gmii_rxd      (rxd),
    .local_mac_addr(local_mac),
    .local_ip_addr (local_ip),
    .local_udp_port(local_port),
    .pkt_done      (pkt_done),
    .pkt_ok        (pkt_ok),
    .err_code      (err_code),
    .payload_len   (payload_len),
    .good_cnt      (good_cnt),
    .err_cnt       (err_cnt)
  );

  // 125 MHz GMII receive clock.
  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Queue the expected report for the next frame and advance the counter model.
  task automatic expectFrame(input logic [2:0] code, input logic [15:0] plen);
    exp_t e;
    if (code == 3'd0) good_exp++;
    else if (code == 3'd1 || code == 3'd6 || code == 3'd7) err_exp++;
    e.ok = (code == 3'd0);
    e.code = code;
    e.plen = plen;
    e.good = good_exp;
    e.errs = err_exp;
    sb.push_back(e);
  endtask

  // Pop and compare on every pkt_done, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && pkt_done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pkt_ok", {31'd0, pkt_ok}, {31'd0, e.ok});
        checkOutput("err_code", {29'd0, err_code}, {29'd0, e.code});
        checkOutput("payload_len", {16'd0, payload_len}, {16'd0, e.plen});
        checkOutput("good_cnt", good_cnt, e.good);
        checkOutput("err_cnt", err_cnt, e.errs);
      end
    end
  end

  // Reflected CRC-32 over the frame, appended little-end first as the FCS.
  task automatic appendFcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    frame_q.push_back(c[7:0]);
    frame_q.push_back(c[15:8]);
    frame_q.push_back(c[23:16]);
    frame_q.push_back(c[31:24]);
  endtask

  // Build a UDP frame with a 20-byte pattern payload; bad_idx>=0 corrupts that payload byte.
  task automatic buildFrame(input logic [47:0] dst, input logic [15:0] etype,
                            input logic [15:0] dport, input int bad_idx);
    frame_q.delete();
    for (int i = 5; i >= 0; i--) frame_q.push_back(dst[8*i +: 8]);
    frame_q.push_back(8'h00); frame_q.push_back(8'h0A); frame_q.push_back(8'h35);
    frame_q.push_back(8'h01); frame_q.push_back(8'h02); frame_q.push_back(8'h03);
    frame_q.push_back(etype[15:8]); frame_q.push_back(etype[7:0]);
    frame_q.push_back(8'h45); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(8'h30); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(8'h40); frame_q.push_back(8'h00); frame_q.push_back(8'h40);
    frame_q.push_back(8'h11); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(8'hC0); frame_q.push_back(8'hA8); frame_q.push_back(8'h00);
    frame_q.push_back(8'h02);
    for (int i = 3; i >= 0; i--) frame_q.push_back(local_ip[8*i +: 8]);
    frame_q.push_back(8'h1F); frame_q.push_back(8'h90);
    frame_q.push_back(dport[15:8]); frame_q.push_back(dport[7:0]);
    frame_q.push_back(8'h00); frame_q.push_back(8'd28);
    frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    for (int i = 0; i < 20; i++) frame_q.push_back((i == bad_idx) ? 8'h21 : pattern[i]);
    appendFcs();
  endtask

  task automatic driveByte(input logic [7:0] b);
    @(posedge clk); #1;
    dv  = 1'b1;
    rxd = b;
  endtask

  // Drive preamble + frame; nsend<0 sends the whole frame, rst_at pulses reset after that byte.
  task automatic applyStimulus(input int npre, input int nsend, input int rst_at, input int gap);
    int n;
    n = (nsend < 0) ? frame_q.size() : nsend;
    for (int i = 0; i < npre; i++) driveByte(8'h55);
    driveByte(8'hD5);
    for (int i = 0; i < n; i++) begin
      driveByte(frame_q[i]);
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        good_exp = 32'd0;
        err_exp  = 32'd0;
      end
    end
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      dv  = 1'b0;
      rxd = 8'h00;
    end
  endtask

  // Bounded wait for every queued report to be consumed.
  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    pattern = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h41, 8'h4C, 8'h49, 8'h4E,
                8'h58, 8'h20, 8'h48, 8'h45, 8'h49, 8'h4A, 8'h49, 8'h4E, 8'h0D, 8'h0A};
    checks     = 0;
    errors     = 0;
    good_exp   = 32'd0;
    err_exp    = 32'd0;
    local_mac  = 48'h000A_3501_FEC0;
    local_ip   = 32'hC0A8_0003;
    local_port = 16'h1F90;
    rst_n      = 1'b0;
    dv         = 1'b0;
    rxd        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_done", {31'd0, pkt_done}, 32'd0);
    checkOutput("rst_good", good_cnt, 32'd0);
    checkOutput("rst_err", err_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] valid frame");
    buildFrame(local_mac, 16'h0800, 16'h1F90, -1);
    expectFrame(3'd0, 16'd20);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] payload byte 5 corrupted");
    buildFrame(local_mac, 16'h0800, 16'h1F90, 5);
    expectFrame(3'd6, 16'd20);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] bad FCS");
    buildFrame(local_mac, 16'h0800, 16'h1F90, -1);
    frame_q[frame_q.size() - 1] = ~frame_q[frame_q.size() - 1];
    expectFrame(3'd7, 16'd20);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] ARP ethertype");
    buildFrame(local_mac, 16'h0806, 16'h1F90, -1);
    expectFrame(3'd3, 16'd0);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] wrong port");
    buildFrame(local_mac, 16'h0800, 16'h1F91, -1);
    expectFrame(3'd5, 16'd0);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] truncated after payload byte 10");
    buildFrame(local_mac, 16'h0800, 16'h1F90, -1);
    expectFrame(3'd7, 16'd20);
    applyStimulus(7, 53, -1, 12); waitDrain();

    $display("[TB] foreign MAC then broadcast MAC");
    buildFrame(48'h0011_2233_4455, 16'h0800, 16'h1F90, -1);
    expectFrame(3'd2, 16'd0);
    applyStimulus(7, -1, -1, 12); waitDrain();
    buildFrame(48'hFFFF_FFFF_FFFF, 16'h0800, 16'h1F90, -1);
    expectFrame(3'd0, 16'd20);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] short preamble and eight-byte preamble");
    buildFrame(local_mac, 16'h0800, 16'h1F90, -1);
    expectFrame(3'd0, 16'd20);
    applyStimulus(1, -1, -1, 12); waitDrain();
    expectFrame(3'd1, 16'd0);
    applyStimulus(8, -1, -1, 12); waitDrain();

    $display("[TB] reset mid-payload");
    applyStimulus(7, -1, 47, 12); waitDrain();
    checkOutput("post_rst_ok", {31'd0, pkt_ok}, 32'd0);
    checkOutput("post_rst_code", {29'd0, err_code}, 32'd0);
    checkOutput("post_rst_plen", {16'd0, payload_len}, 32'd0);
    checkOutput("post_rst_good", good_cnt, 32'd0);
    checkOutput("post_rst_err", err_cnt, 32'd0);
    expectFrame(3'd0, 16'd20);
    applyStimulus(7, -1, -1, 12); waitDrain();

    $display("[TB] back-to-back frames");
    expectFrame(3'd0, 16'd20);
    applyStimulus(7, -1, -1, 1);
    expectFrame(3'd0, 16'd20);
    applyStimulus(7, -1, -1, 12); waitDrain();
    checkOutput("final_good", good_cnt, good_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
